if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 18 +
 rtl/if_stage_pc_target_gen.sv | 38 +++
 rtl/if_stage.sv | 86 ++++++++
 tb/tb_if_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline types and constants for the fetch, decode and execute stages.
// Fields are big-endian: bit 0 is the MSB.
package if_stage_pkg;

    typedef logic [0:31] pc_t;

    localparam pc_t PC_STEP  = 32'd4;
    localparam pc_t NOP_WORD = 32'h0000_0000;

    function automatic pc_t sext16(input logic [0:15] value);
        return {{16{value[0]}}, value};
    endfunction

    function automatic pc_t sext26(input logic [0:25] value);
        return {{6{value[0]}}, value};
    endfunction

endpackage

// File: rtl/if_stage_pc_target_gen.sv
// Branch/jump target selection from IF/ID contents; also reused by decode
// for branch-target forwarding.
module pc_target_gen
    import if_stage_pkg::*;
(
    input  pc_t         pc_plus4,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_use_reg,
    input  pc_t         reg_target,
    input  logic [0:15] imm16,
    input  logic [0:25] offset26,
    output pc_t         target
);

    pc_t branch_target_s;
    pc_t jump_target_s;
    pc_t reg_jump_target_s;

    assign branch_target_s   = pc_plus4 + sext16(imm16);
    assign jump_target_s     = pc_plus4 + sext26(offset26);
    assign reg_jump_target_s = {reg_target[0:29], 2'b00};

    // Register jump outranks displacement jump, which outranks a taken branch.
    always_comb begin
        target = branch_target_s;
        if (jump && jump_use_reg) begin
            target = reg_jump_target_s;
        end else if (jump) begin
            target = jump_target_s;
        end else if (branch_taken) begin
            target = branch_target_s;
        end else begin
            target = branch_target_s;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: program counter plus the IF/ID pipeline register, with
// decode stalls and a one-bubble squash on branch/jump redirects.
module if_stage
    import if_stage_pkg::*;
#(
    parameter pc_t RESET_PC = 32'h0000_0000,
    parameter pc_t NOP_WORD = if_stage_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [0:31] imem_addr,
    input  logic [0:31] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_use_reg,
    input  logic [0:31] reg_target,
    input  logic [0:15] imm16,
    input  logic [0:25] offset26,
    output logic [0:31] instr_id,
    output logic [0:31] pc_id,
    output logic [0:31] pc_plus4_id,
    output logic        valid_id
);

    pc_t  pc_r;
    pc_t  instr_id_r;
    pc_t  pc_id_r;
    pc_t  pc_plus4_id_r;
    logic valid_id_r;

    pc_t  target_s;
    pc_t  pc_next_seq_s;
    logic redirect_s;

    pc_target_gen u_pc_target_gen (
        .pc_plus4     (pc_plus4_id_r),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_use_reg (jump_use_reg),
        .reg_target   (reg_target),
        .imm16        (imm16),
        .offset26     (offset26),
        .target       (target_s)
    );

    // Control from decode only counts when it describes a real instruction.
    assign redirect_s    = valid_id_r && (branch_taken || jump);
    assign pc_next_seq_s = pc_r + PC_STEP;

    // PC and IF/ID update: reset, then stall, then redirect, then sequential.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            instr_id_r    <= NOP_WORD;
            pc_id_r       <= 32'h0000_0000;
            pc_plus4_id_r <= 32'h0000_0000;
            valid_id_r    <= 1'b0;
        end else if (stall) begin
            pc_r          <= pc_r;
            instr_id_r    <= instr_id_r;
            pc_id_r       <= pc_id_r;
            pc_plus4_id_r <= pc_plus4_id_r;
            valid_id_r    <= valid_id_r;
        end else if (redirect_s) begin
            pc_r          <= target_s;
            instr_id_r    <= NOP_WORD;
            pc_id_r       <= 32'h0000_0000;
            pc_plus4_id_r <= 32'h0000_0000;
            valid_id_r    <= 1'b0;
        end else begin
            pc_r          <= pc_next_seq_s;
            instr_id_r    <= imem_data;
            pc_id_r       <= pc_r;
            pc_plus4_id_r <= pc_next_seq_s;
            valid_id_r    <= 1'b1;
        end
    end

    assign imem_addr   = pc_r;
    assign instr_id    = instr_id_r;
    assign pc_id       = pc_id_r;
    assign pc_plus4_id = pc_plus4_id_r;
    assign valid_id    = valid_id_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, branch, jumps,
// bubble handling, PC wrap and reset during redirect.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic [0:31] imem_addr;
    logic [0:31] imem_data;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic        jump_use_reg;
    logic [0:31] reg_target;
    logic [0:15] imm16;
    logic [0:25] offset26;
    logic [0:31] instr_id;
    logic [0:31] pc_id;
    logic [0:31] pc_plus4_id;
    logic        valid_id;

    int vec_cnt;
    int err_cnt;

    if_stage #(
        .RESET_PC (32'h0000_0100),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_use_reg (jump_use_reg),
        .reg_target   (reg_target),
        .imm16        (imm16),
        .offset26     (offset26),
        .instr_id     (instr_id),
        .pc_id        (pc_id),
        .pc_plus4_id  (pc_plus4_id),
        .valid_id     (valid_id)
    );

    // Instruction memory: word at address A is A ^ 32'hDEAD_0000.
    assign imem_data = imem_addr ^ 32'hDEAD_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] addr, input logic [31:0] ins,
                            input logic [31:0] pcid, input logic [31:0] pc4, input logic vld);
        check_val({tag, ".addr"},  imem_addr,   addr);
        check_val({tag, ".instr"}, instr_id,    ins);
        check_val({tag, ".pc_id"}, pc_id,       pcid);
        check_val({tag, ".pc4"},   pc_plus4_id, pc4);
        check_val({tag, ".valid"}, {31'd0, valid_id}, {31'd0, vld});
    endtask

    initial begin
        vec_cnt      = 0;
        err_cnt      = 0;
        reset        = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jump_use_reg = 1'b0;
        reg_target   = 32'h0000_0000;
        imm16        = 16'h0000;
        offset26     = 26'h000_0000;

        tick();
        tick();
        check_id("reset", 32'h100, 32'h0, 32'h0, 32'h0, 1'b0);

        reset = 1'b0;
        tick();
        check_id("seq0", 32'h104, 32'hDEAD_0100, 32'h100, 32'h104, 1'b1);
        tick();
        check_id("seq1", 32'h108, 32'hDEAD_0104, 32'h104, 32'h108, 1'b1);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_id("stall", 32'h108, 32'hDEAD_0104, 32'h104, 32'h108, 1'b1);
        end
        stall = 1'b0;
        tick();
        check_id("resume", 32'h10C, 32'hDEAD_0108, 32'h108, 32'h10C, 1'b1);

        // Register jump to 0x200 sets up the branch test.
        jump = 1'b1; jump_use_reg = 1'b1; reg_target = 32'h0000_0203;
        tick();
        check_id("jr200", 32'h200, 32'h0, 32'h0, 32'h0, 1'b0);
        jump = 1'b0; jump_use_reg = 1'b0;
        tick();
        check_id("at200", 32'h204, 32'hDEAD_0200, 32'h200, 32'h204, 1'b1);

        branch_taken = 1'b1; imm16 = 16'hFFF0;
        tick();
        check_id("br", 32'h1F4, 32'h0, 32'h0, 32'h0, 1'b0);
        // branch_taken stays high across the bubble and must be ignored.
        tick();
        check_id("stale", 32'h1F8, 32'hDEAD_01F4, 32'h1F4, 32'h1F8, 1'b1);
        branch_taken = 1'b0;

        jump = 1'b1; jump_use_reg = 1'b1; reg_target = 32'h0000_0403;
        tick();
        check_id("jr400", 32'h400, 32'h0, 32'h0, 32'h0, 1'b0);
        jump = 1'b0; jump_use_reg = 1'b0;
        tick();
        check_id("at400", 32'h404, 32'hDEAD_0400, 32'h400, 32'h404, 1'b1);

        stall = 1'b1; branch_taken = 1'b1; imm16 = 16'h0010;
        tick();
        check_id("stbr", 32'h404, 32'hDEAD_0400, 32'h400, 32'h404, 1'b1);
        stall = 1'b0;
        tick();
        check_id("brlate", 32'h414, 32'h0, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        tick();
        check_id("at414", 32'h418, 32'hDEAD_0414, 32'h414, 32'h418, 1'b1);

        // Backward displacement jump: 0x418 + sext(26'h3FF_FBE4) = 0xFFFF_FFFC.
        jump = 1'b1; offset26 = 26'h3FF_FBE4;
        tick();
        check_id("jneg", 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b0);
        jump = 1'b0;
        tick();
        check_id("wrap", 32'h0, 32'h2152_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);

        // Reset outranks a simultaneous stall and redirect.
        reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; imm16 = 16'h0008;
        tick();
        check_id("rstredir", 32'h100, 32'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        tick();
        check_id("post", 32'h104, 32'hDEAD_0100, 32'h100, 32'h104, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
